// File: rtl/simd_regfile_pkg.sv
// Shared types for the SIMD register file: scrub/ready controller state.
package simd_regfile_pkg;

  typedef enum logic {SCRUB, READY} simd_rf_state_e;

endpackage

// File: rtl/simd_regfile_lane.sv
// One SIMD lane: single write port, read_ports_p synchronous read ports with
// write-first bypass and a zero_i override on the read registers.
module simd_regfile_lane #(
  parameter int unsigned width_p       = 33,
  parameter int unsigned els_p         = 32,
  parameter int unsigned read_ports_p  = 3,
  parameter int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                zero_i,
  input  logic                                w_v_i,
  input  logic [addr_width_lp-1:0]            w_addr_i,
  input  logic [width_p-1:0]                  w_data_i,
  input  logic [read_ports_p-1:0]             r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0] r_addr_i,
  output logic [read_ports_p*width_p-1:0]     r_data_o
);

  localparam logic [addr_width_lp:0] ElsL = (addr_width_lp + 1)'(els_p);

  logic [width_p-1:0]              mem_q [els_p];
  logic [read_ports_p*width_p-1:0] r_data_d, r_data_q;
  logic                            w_ok;

  // Out-of-range writes are dropped so a non-power-of-two depth stays safe.
  assign w_ok = w_v_i && ({1'b0, w_addr_i} < ElsL);

  always_ff @(posedge clk_i) begin
    if (w_ok) mem_q[w_addr_i] <= w_data_i;
  end

  always_comb begin
    r_data_d = r_data_q;
    for (int p = 0; p < read_ports_p; p++) begin
      if (zero_i) begin
        r_data_d[p*width_p +: width_p] = '0;
      end else if (r_v_i[p]) begin
        if (w_ok && (w_addr_i == r_addr_i[p*addr_width_lp +: addr_width_lp])) begin
          r_data_d[p*width_p +: width_p] = w_data_i;
        end else if ({1'b0, r_addr_i[p*addr_width_lp +: addr_width_lp]} < ElsL) begin
          r_data_d[p*width_p +: width_p] = mem_q[r_addr_i[p*addr_width_lp +: addr_width_lp]];
        end else begin
          r_data_d[p*width_p +: width_p] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_data_q <= '0;
    else            r_data_q <= r_data_d;
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/simd_regfile_sync.sv
// Multi-lane SIMD register file: lane 0 serves every read port, upper lanes only
// serve simd_port_p. A scrub FSM zeroes all entries after reset.
module simd_regfile_sync import simd_regfile_pkg::*; #(
  parameter int unsigned width_p       = 33,
  parameter int unsigned els_p         = 32,
  parameter int unsigned lanes_p       = 4,
  parameter int unsigned read_ports_p  = 3,
  parameter int unsigned simd_port_p   = 1,
  parameter int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  output logic                                  ready_o,
  input  logic [lanes_p-1:0]                    w_v_i,
  input  logic [addr_width_lp-1:0]              w_addr_i,
  input  logic [lanes_p*width_p-1:0]            w_data_i,
  input  logic [read_ports_p-1:0]               r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0] r_addr_i,
  output logic [read_ports_p*width_p-1:0]       r_data_o,
  output logic [(lanes_p-1)*width_p-1:0]        simd_data_o
);

  localparam logic [addr_width_lp-1:0] LastAddr = addr_width_lp'(els_p - 1);

  simd_rf_state_e             state_q, state_d;
  logic [addr_width_lp-1:0]   cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic                       scrub;
  logic [lanes_p-1:0]         lane_w_v;
  logic [addr_width_lp-1:0]   lane_w_addr;
  logic [lanes_p*width_p-1:0] lane_w_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SCRUB) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end
    ready_d = (state_d == READY);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= SCRUB;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign scrub   = (state_q == SCRUB);

  // Scrub owns the write port; external traffic is ignored until READY.
  always_comb begin
    lane_w_v    = w_v_i;
    lane_w_addr = w_addr_i;
    lane_w_data = w_data_i;
    if (scrub) begin
      lane_w_v    = '1;
      lane_w_addr = cnt_q;
      lane_w_data = '0;
    end
  end

  simd_regfile_lane #(
    .width_p      (width_p),
    .els_p        (els_p),
    .read_ports_p (read_ports_p),
    .addr_width_lp(addr_width_lp)
  ) u_lane0 (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .zero_i   (scrub),
    .w_v_i    (lane_w_v[0]),
    .w_addr_i (lane_w_addr),
    .w_data_i (lane_w_data[width_p-1:0]),
    .r_v_i    (r_v_i),
    .r_addr_i (r_addr_i),
    .r_data_o (r_data_o)
  );

  for (genvar l = 1; l < lanes_p; l++) begin : g_upper
    simd_regfile_lane #(
      .width_p      (width_p),
      .els_p        (els_p),
      .read_ports_p (1),
      .addr_width_lp(addr_width_lp)
    ) u_lane (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .zero_i   (scrub),
      .w_v_i    (lane_w_v[l]),
      .w_addr_i (lane_w_addr),
      .w_data_i (lane_w_data[l*width_p +: width_p]),
      .r_v_i    (r_v_i[simd_port_p]),
      .r_addr_i (r_addr_i[simd_port_p*addr_width_lp +: addr_width_lp]),
      .r_data_o (simd_data_o[(l-1)*width_p +: width_p])
    );
  end

endmodule

// File: tb/tb_simd_regfile_sync.sv
// Scoreboard bench for simd_regfile_sync: default 4-lane instance plus a
// 2-lane/8-entry instance sharing the clock and reset.
module tb_simd_regfile_sync;

  typedef struct {
    int           due;
    int           port;
    logic [32:0]  rd;
    bit           chk_simd;
    logic [98:0]  simd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ready;
  logic [3:0]   w_v = '0;
  logic [4:0]   w_addr = '0;
  logic [131:0] w_data = '0;
  logic [2:0]   r_v = '0;
  logic [14:0]  r_addr = '0;
  logic [98:0]  r_data;
  logic [98:0]  simd;

  logic         ready2;
  logic [1:0]   w_v2 = '0;
  logic [2:0]   w_addr2 = '0;
  logic [65:0]  w_data2 = '0;
  logic [1:0]   r_v2 = '0;
  logic [5:0]   r_addr2 = '0;
  logic [65:0]  r_data2;
  logic [32:0]  simd2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simd_regfile_sync dut (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(r_data), .simd_data_o(simd)
  );

  simd_regfile_sync #(
    .width_p(33), .els_p(8), .lanes_p(2), .read_ports_p(2), .simd_port_p(0)
  ) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready2),
    .w_v_i(w_v2), .w_addr_i(w_addr2), .w_data_i(w_data2),
    .r_v_i(r_v2), .r_addr_i(r_addr2), .r_data_o(r_data2), .simd_data_o(simd2)
  );

  function automatic logic [98:0] simd3(input logic [32:0] l3, input logic [32:0] l2,
                                        input logic [32:0] l1);
    return {l3, l2, l1};
  endfunction

  function automatic logic [131:0] wd4(input logic [32:0] l3, input logic [32:0] l2,
                                       input logic [32:0] l1, input logic [32:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [131:0] got, input logic [131:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_rd(input int port, input logic [32:0] rd, input bit cs,
                           input logic [98:0] sd);
    exp_t x;
    x.due = cyc + 1;
    x.port = port;
    x.rd = rd;
    x.chk_simd = cs;
    x.simd = sd;
    sb.push_back(x);
  endtask

  task automatic step(input logic [3:0] wv, input logic [4:0] wa, input logic [131:0] wd,
                      input logic [2:0] rv, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] a2);
    w_v = wv;
    w_addr = wa;
    w_data = wd;
    r_v = rv;
    r_addr = {a2, a1, a0};
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic ready_wait();
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ready_edge%0d", i), 132'(ready), 132'(i == 32));
      chk($sformatf("ready2_edge%0d", i), 132'(ready2), 132'(i >= 8));
    end
    chk("scrub_rdata_zero", 132'(r_data), 132'd0);
    chk("scrub_simd_zero", 132'(simd), 132'd0);
  endtask

  // Monitor: read registers update once per edge, so every queued expectation
  // is due on a specific cycle and sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL sb_late: got cyc %0d want cyc %0d", cyc, e.due);
      end else if (r_data[e.port*33 +: 33] !== e.rd) begin
        errors++;
        $display("FAIL rd_port%0d cyc%0d: got %h want %h", e.port, cyc,
                 r_data[e.port*33 +: 33], e.rd);
      end
      if (e.chk_simd) begin
        checks++;
        if (simd !== e.simd) begin
          errors++;
          $display("FAIL simd cyc%0d: got %h want %h", cyc, simd, e.simd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 132'(ready), 132'd0);
    chk("rst_rdata", 132'(r_data), 132'd0);
    chk("rst_simd", 132'(simd), 132'd0);
    chk("rst_ready2", 132'(ready2), 132'd0);
    rst_n = 1'b1;
    ready_wait();

    // Scrubbed entries read zero; issued in the first ready cycle.
    expect_rd(0, 33'd0, 1'b0, 99'd0);
    expect_rd(1, 33'd0, 1'b1, 99'd0);
    expect_rd(2, 33'd0, 1'b0, 99'd0);
    step(4'b0000, 5'd0, 132'd0, 3'b111, 5'd0, 5'd17, 5'd31);

    step(4'b0001, 5'd0, wd4(33'd5, 33'd4, 33'd3, 33'd2), 3'b000, 5'd0, 5'd0, 5'd0);
    expect_rd(1, 33'd2, 1'b1, simd3(33'd0, 33'd0, 33'd0));
    step(4'b0000, 5'd0, 132'd0, 3'b010, 5'd0, 5'd0, 5'd0);

    step(4'b1111, 5'd0, wd4(33'd7, 33'd7, 33'd7, 33'd7), 3'b000, 5'd0, 5'd0, 5'd0);
    expect_rd(1, 33'd7, 1'b1, simd3(33'd7, 33'd7, 33'd7));
    step(4'b0000, 5'd0, 132'd0, 3'b010, 5'd0, 5'd0, 5'd0);

    step(4'b1111, 5'd30, wd4(33'd1, 33'd1, 33'd1, 33'd1), 3'b000, 5'd0, 5'd0, 5'd0);
    // Per-lane bypass: only lane 1 is written, so only it returns new data.
    expect_rd(0, 33'd1, 1'b0, 99'd0);
    expect_rd(1, 33'd1, 1'b1, simd3(33'd1, 33'd1, 33'd9));
    step(4'b0010, 5'd30, wd4(33'h1AA, 33'h1AA, 33'd9, 33'h1AA), 3'b011, 5'd30, 5'd30, 5'd0);

    expect_rd(0, 33'd7, 1'b0, 99'd0);
    expect_rd(1, 33'd1, 1'b1, simd3(33'd1, 33'd1, 33'd9));
    expect_rd(2, 33'd1, 1'b0, 99'd0);
    step(4'b0000, 5'd0, 132'd0, 3'b111, 5'd0, 5'd30, 5'd30);

    for (int k = 0; k < 5; k++) begin
      expect_rd(0, 33'd7, 1'b0, 99'd0);
      expect_rd(1, 33'd1, 1'b1, simd3(33'd1, 33'd1, 33'd9));
      expect_rd(2, 33'd1, 1'b0, 99'd0);
      step(4'b1111, (k % 2 != 0) ? 5'd30 : 5'd0,
           wd4(33'(85 + k), 33'(85 + k), 33'(85 + k), 33'(85 + k)),
           3'b000, 5'd0, 5'd30, 5'd30);
    end

    expect_rd(0, 33'h59, 1'b0, 99'd0);
    expect_rd(1, 33'h58, 1'b1, simd3(33'h58, 33'h58, 33'h58));
    expect_rd(2, 33'd0, 1'b0, 99'd0);
    step(4'b0000, 5'd0, 132'd0, 3'b111, 5'd0, 5'd30, 5'd3);

    // Full-width value through bypass, then from storage.
    expect_rd(1, 33'h1_FFFF_FFFF, 1'b1, {99{1'b1}});
    expect_rd(2, 33'h1_FFFF_FFFF, 1'b0, 99'd0);
    step(4'b1111, 5'd3, {132{1'b1}}, 3'b110, 5'd0, 5'd3, 5'd3);
    expect_rd(1, 33'h1_FFFF_FFFF, 1'b1, {99{1'b1}});
    expect_rd(2, 33'h1_FFFF_FFFF, 1'b0, 99'd0);
    step(4'b0000, 5'd0, 132'd0, 3'b110, 5'd0, 5'd3, 5'd3);
    drain();

    // Small instance: lane 1 of port 0 drives the 33-bit simd output.
    w_v2 = 2'b11;
    w_addr2 = 3'd5;
    w_data2 = {33'h1_2345_6789, 33'h11};
    @(posedge clk);
    #1;
    w_v2 = 2'b00;
    r_v2 = 2'b01;
    r_addr2 = {3'd0, 3'd5};
    @(posedge clk);
    #1;
    r_v2 = 2'b00;
    chk("dut2_rd0", 132'(r_data2[32:0]), 132'h11);
    chk("dut2_simd", 132'(simd2), 132'h1_2345_6789);

    // Reset mid-traffic with writes to addr 3 kept asserted through re-scrub.
    w_v = 4'b1111;
    w_addr = 5'd3;
    w_data = {132{1'b1}};
    r_v = 3'b111;
    r_addr = {5'd3, 5'd3, 5'd3};
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", 132'(r_data), 132'd0);
    chk("midrst_simd", 132'(simd), 132'd0);
    chk("midrst_ready", 132'(ready), 132'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midscrub_ready", 132'(ready), 132'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_wait();

    expect_rd(0, 33'd0, 1'b0, 99'd0);
    expect_rd(1, 33'd0, 1'b1, 99'd0);
    expect_rd(2, 33'd0, 1'b0, 99'd0);
    step(4'b0000, 5'd0, 132'd0, 3'b111, 5'd3, 5'd3, 5'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
